// File: rtl/cci_arb_pkg.sv
// Shared definitions for the CCI tx1 write arbiter: default widths, mdata tag
// placement and the index/counter width helpers used by the arbiter and picker.
package cci_arb_pkg;

    localparam int unsigned TXHDR_W_DEF = 61;
    localparam int unsigned RXHDR_W_DEF = 18;
    localparam int unsigned CL_W_DEF    = 512;

    // The requester tag lives in the low mdata bits, same position in tx and rx headers.
    localparam int unsigned MDATA_LSB   = 0;
    localparam int unsigned MDATA_W     = 16;

    typedef logic [TXHDR_W_DEF-1:0] tx_hdr_t;
    typedef logic [MDATA_W-1:0]     mdata_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned max_cnt);
        return $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/cci_tx1_wr_arbiter_picker.sv
// Combinational round-robin picker: first eligible requester at or above ptr_i,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module cci_rr_picker
    import cci_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        pos         = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = IDX_W'((32'(ptr_i) + k) % NUM_REQ);
            if (!valid_o && elig_i[pos]) begin
                grant_o[pos] = 1'b1;
                grant_idx_o  = pos;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cci_tx1_wr_arbiter.sv
// Round-robin sharing of CCI tx channel 1 between NUM_REQ requesters, with
// per-requester outstanding-write tracking from rx0/rx1 write responses.
module cci_tx1_wr_arbiter
    import cci_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned TXHDR_WIDTH     = TXHDR_W_DEF,
    parameter int unsigned RXHDR_WIDTH     = RXHDR_W_DEF,
    parameter int unsigned CACHE_WIDTH     = CL_W_DEF,
    parameter int unsigned TAG_LSB         = MDATA_LSB,
    parameter int unsigned MAX_OUTSTANDING = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           lp_initdone,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*TXHDR_WIDTH-1:0] req_header,
    input  logic [NUM_REQ*CACHE_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [TXHDR_WIDTH-1:0]         tx_c1_header,
    output logic [CACHE_WIDTH-1:0]         tx_c1_data,
    output logic                           tx_c1_wrvalid,
    input  logic                           tx_c1_almostfull,
    input  logic [RXHDR_WIDTH-1:0]         rx_c0_header,
    input  logic                           rx_c0_wrvalid,
    input  logic [RXHDR_WIDTH-1:0]         rx_c1_header,
    input  logic                           rx_c1_wrvalid,
    output logic [NUM_REQ-1:0]             wr_done0,
    output logic [NUM_REQ-1:0]             wr_done1,
    output logic                           idle,
    output logic                           err_unexpected_rsp
);

    localparam int unsigned      IDX_W    = idx_w(NUM_REQ);
    localparam int unsigned      CNT_W    = cnt_w(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]            elig;
    logic [NUM_REQ-1:0]            grant;
    logic [IDX_W-1:0]              grant_idx;
    logic                          grant_any;
    logic                          grant_ok;
    logic                          hs;

    logic [IDX_W-1:0]              ptr_q, ptr_d;
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_REQ-1:0]            underflow;
    logic [NUM_REQ-1:0]            done0_d, done1_d;
    logic [NUM_REQ-1:0]            done0_q, done1_q;

    logic [TXHDR_WIDTH-1:0]        hdr_arr  [NUM_REQ];
    logic [CACHE_WIDTH-1:0]        data_arr [NUM_REQ];
    logic [TXHDR_WIDTH-1:0]        hdr_tagged;
    logic [TXHDR_WIDTH-1:0]        hdr_q;
    logic [CACHE_WIDTH-1:0]        data_q;
    logic                          wrvalid_q;
    logic                          err_q;

    logic [IDX_W-1:0]              rx0_tag, rx1_tag;
    logic                          unused_rx_bits;

    // Reset is folded in so req_ready reads zero for the whole reset window.
    assign grant_ok = lp_initdone && !tx_c1_almostfull && !reset;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_unpack
        assign hdr_arr[g]  = req_header[g*TXHDR_WIDTH +: TXHDR_WIDTH];
        assign data_arr[g] = req_data[g*CACHE_WIDTH +: CACHE_WIDTH];
        assign elig[g]     = req_valid[g] && (cnt_q[g] < MAX_CNT);
    end

    cci_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .elig_i      (elig),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .valid_o     (grant_any)
    );

    assign req_ready = grant_ok ? grant : '0;
    assign hs        = grant_ok && grant_any;

    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        hdr_tagged                     = hdr_arr[grant_idx];
        hdr_tagged[TAG_LSB +: IDX_W]   = grant_idx;
    end

    assign rx0_tag        = rx_c0_header[TAG_LSB +: IDX_W];
    assign rx1_tag        = rx_c1_header[TAG_LSB +: IDX_W];
    assign unused_rx_bits = ^{rx_c0_header, rx_c1_header};

    // Net update = +issue - rx0 - rx1, evaluated one bit wider so a shortfall is visible.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        logic           inc, dec0, dec1;
        logic [CNT_W:0] up, down;

        assign inc  = hs && grant[g];
        assign dec0 = rx_c0_wrvalid && (rx0_tag == IDX_W'(g));
        assign dec1 = rx_c1_wrvalid && (rx1_tag == IDX_W'(g));

        assign up   = {1'b0, cnt_q[g]} + {{CNT_W{1'b0}}, inc};
        assign down = {{CNT_W{1'b0}}, dec0} + {{CNT_W{1'b0}}, dec1};

        assign underflow[g] = (up < down);
        assign cnt_d[g]     = underflow[g] ? '0 : CNT_W'(up - down);
        assign done0_d[g]   = dec0;
        assign done1_d[g]   = dec1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            cnt_q     <= '0;
            wrvalid_q <= 1'b0;
            hdr_q     <= '0;
            data_q    <= '0;
            done0_q   <= '0;
            done1_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            wrvalid_q <= hs;
            if (hs) begin
                hdr_q  <= hdr_tagged;
                data_q <= data_arr[grant_idx];
            end
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err_q     <= err_q || (|underflow);
        end
    end

    assign tx_c1_header       = hdr_q;
    assign tx_c1_data         = data_q;
    assign tx_c1_wrvalid      = wrvalid_q;
    assign wr_done0           = done0_q;
    assign wr_done1           = done1_q;
    assign err_unexpected_rsp = err_q;
    assign idle               = (cnt_q == '0) && !wrvalid_q;

endmodule

// File: tb/tb_cci_tx1_wr_arbiter.sv
// Scoreboard bench for cci_tx1_wr_arbiter: a reference grant/counter model
// predicts each write, completion pulse and flag; scenario tasks add targeted checks.
module tb_cci_tx1_wr_arbiter;

    localparam int N  = 4;
    localparam int HW = 61;
    localparam int RW = 18;
    localparam int CW = 512;
    localparam int TL = 0;
    localparam int MO = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              lp_initdone;
    logic [N-1:0]      req_valid;
    logic [N*HW-1:0]   req_header;
    logic [N*CW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [HW-1:0]     tx_c1_header;
    logic [CW-1:0]     tx_c1_data;
    logic              tx_c1_wrvalid;
    logic              tx_c1_almostfull;
    logic [RW-1:0]     rx_c0_header;
    logic              rx_c0_wrvalid;
    logic [RW-1:0]     rx_c1_header;
    logic              rx_c1_wrvalid;
    logic [N-1:0]      wr_done0;
    logic [N-1:0]      wr_done1;
    logic              idle;
    logic              err_unexpected_rsp;

    always #5 clk = ~clk;

    cci_tx1_wr_arbiter #(
        .NUM_REQ         (N),
        .TXHDR_WIDTH     (HW),
        .RXHDR_WIDTH     (RW),
        .CACHE_WIDTH     (CW),
        .TAG_LSB         (TL),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .lp_initdone        (lp_initdone),
        .req_valid          (req_valid),
        .req_header         (req_header),
        .req_data           (req_data),
        .req_ready          (req_ready),
        .tx_c1_header       (tx_c1_header),
        .tx_c1_data         (tx_c1_data),
        .tx_c1_wrvalid      (tx_c1_wrvalid),
        .tx_c1_almostfull   (tx_c1_almostfull),
        .rx_c0_header       (rx_c0_header),
        .rx_c0_wrvalid      (rx_c0_wrvalid),
        .rx_c1_header       (rx_c1_header),
        .rx_c1_wrvalid      (rx_c1_wrvalid),
        .wr_done0           (wr_done0),
        .wr_done1           (wr_done1),
        .idle               (idle),
        .err_unexpected_rsp (err_unexpected_rsp)
    );

    typedef struct {
        logic [HW-1:0] hdr;
        logic [CW-1:0] data;
    } tx_t;

    tx_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    int ptr_m;
    int cnt_m [N];
    bit err_m;

    logic [N-1:0] obs_ready, obs_done0, obs_done1;
    logic         obs_wrvalid, obs_err, obs_idle;

    task automatic model_reset();
        ptr_m = 0;
        err_m = 1'b0;
        for (int i = 0; i < N; i++) cnt_m[i] = 0;
        exp_q.delete();
    endtask

    task automatic model_dec(input int t);
        if (cnt_m[t] == 0) err_m = 1'b1;
        else cnt_m[t]--;
    endtask

    // One clock: entered at a negedge with control inputs set, returns at the next negedge.
    task automatic step();
        logic [N-1:0] exp_ready, exp_d0, exp_d1;
        int           g, p, t0, t1;
        bit           hs, all_zero;
        tx_t          e;

        for (int i = 0; i < N; i++) begin
            req_header[i*HW +: HW] = HW'({$urandom, $urandom});
            for (int w = 0; w < CW/32; w++) req_data[i*CW + w*32 +: 32] = $urandom;
        end
        #1;
        exp_ready = '0;
        g = -1;
        if (lp_initdone && !tx_c1_almostfull) begin
            for (int k = 0; k < N; k++) begin
                p = (ptr_m + k) % N;
                if (g < 0 && req_valid[p] && cnt_m[p] < MO) g = p;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        obs_ready = req_ready;
        n_checks++;
        if (req_ready !== exp_ready) $display("FAIL req_ready: got %b want %b", req_ready, exp_ready);
        else n_pass++;

        hs = (g >= 0);
        if (hs) begin
            e.hdr          = req_header[g*HW +: HW];
            e.hdr[TL +: 2] = 2'(g);
            e.data         = req_data[g*CW +: CW];
            exp_q.push_back(e);
            cnt_m[g]++;
            ptr_m = (g + 1) % N;
        end
        t0 = int'(rx_c0_header[TL +: 2]);
        t1 = int'(rx_c1_header[TL +: 2]);
        exp_d0 = rx_c0_wrvalid ? (N'(1) << t0) : '0;
        exp_d1 = rx_c1_wrvalid ? (N'(1) << t1) : '0;
        if (rx_c0_wrvalid) model_dec(t0);
        if (rx_c1_wrvalid) model_dec(t1);

        @(posedge clk);
        @(negedge clk);
        obs_wrvalid = tx_c1_wrvalid;
        obs_done0   = wr_done0;
        obs_done1   = wr_done1;
        obs_err     = err_unexpected_rsp;
        obs_idle    = idle;

        n_checks++;
        if (tx_c1_wrvalid !== hs) $display("FAIL wrvalid: got %b want %b", tx_c1_wrvalid, hs);
        else n_pass++;
        if (hs && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (tx_c1_header !== e.hdr || tx_c1_data !== e.data)
                $display("FAIL tx_payload: got hdr %h data %h want hdr %h data %h",
                         tx_c1_header, tx_c1_data, e.hdr, e.data);
            else n_pass++;
        end
        n_checks++;
        if (wr_done0 !== exp_d0 || wr_done1 !== exp_d1)
            $display("FAIL wr_done: got %b/%b want %b/%b", wr_done0, wr_done1, exp_d0, exp_d1);
        else n_pass++;
        n_checks++;
        if (err_unexpected_rsp !== err_m) $display("FAIL err: got %b want %b", err_unexpected_rsp, err_m);
        else n_pass++;
        all_zero = 1'b1;
        for (int i = 0; i < N; i++) if (cnt_m[i] != 0) all_zero = 1'b0;
        n_checks++;
        if (idle !== (all_zero && !hs)) $display("FAIL idle: got %b want %b", idle, all_zero && !hs);
        else n_pass++;

        rx_c0_wrvalid = 1'b0;
        rx_c1_wrvalid = 1'b0;
    endtask

    task automatic set_rx0(input int tag);
        rx_c0_header          = RW'($urandom);
        rx_c0_header[TL +: 2] = 2'(tag);
        rx_c0_wrvalid         = 1'b1;
    endtask

    task automatic set_rx1(input int tag);
        rx_c1_header          = RW'($urandom);
        rx_c1_header[TL +: 2] = 2'(tag);
        rx_c1_wrvalid         = 1'b1;
    endtask

    task automatic test_drain();
        int a, b;
        req_valid = '0;
        for (int it = 0; it < 64; it++) begin
            a = -1;
            b = -1;
            for (int i = 0; i < N; i++) if (a < 0 && cnt_m[i] > 0) a = i;
            if (a < 0) break;
            if (cnt_m[a] >= 2) b = a;
            else for (int i = a + 1; i < N; i++) if (b < 0 && cnt_m[i] > 0) b = i;
            set_rx0(a);
            if (b >= 0) set_rx1(b);
            step();
        end
        n_checks++;
        if (obs_idle !== 1'b1) $display("FAIL drain_idle: got %b want 1", obs_idle);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b0; lp_initdone = 1'b0; req_valid = '0; req_header = '0; req_data = '0;
        tx_c1_almostfull = 1'b0; rx_c0_header = '0; rx_c0_wrvalid = 1'b0;
        rx_c1_header = '0; rx_c1_wrvalid = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_checks++; if (req_ready !== '0) $display("FAIL rst_ready: got %b want 0", req_ready); else n_pass++;
        n_checks++; if (tx_c1_wrvalid !== 1'b0) $display("FAIL rst_wrvalid: got %b want 0", tx_c1_wrvalid); else n_pass++;
        n_checks++; if (tx_c1_header !== '0 || tx_c1_data !== '0) $display("FAIL rst_payload: got hdr %h want 0", tx_c1_header); else n_pass++;
        n_checks++; if (wr_done0 !== '0 || wr_done1 !== '0) $display("FAIL rst_done: got %b/%b want 0/0", wr_done0, wr_done1); else n_pass++;
        n_checks++; if (err_unexpected_rsp !== 1'b0) $display("FAIL rst_err: got %b want 0", err_unexpected_rsp); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL rst_idle: got %b want 1", idle); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_round_robin();
        lp_initdone = 1'b1;
        req_valid   = '1;
        for (int k = 0; k < 12; k++) begin
            step();
            n_checks++;
            if (obs_ready !== (N'(1) << (k % N))) $display("FAIL rr_order[%0d]: got %b want %b", k, obs_ready, N'(1) << (k % N));
            else n_pass++;
            n_checks++;
            if (obs_wrvalid !== 1'b1) $display("FAIL rr_stream[%0d]: got %b want 1", k, obs_wrvalid);
            else n_pass++;
        end
        test_drain();
    endtask

    task automatic test_outstanding_limit();
        req_valid = 4'b0100;
        for (int k = 0; k < MO; k++) begin
            step();
            n_checks++;
            if (obs_ready !== 4'b0100) $display("FAIL lim_fill[%0d]: got %b want 0100", k, obs_ready);
            else n_pass++;
        end
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            step();
            n_checks++;
            if (obs_ready[2] !== 1'b0 || obs_ready === '0) $display("FAIL lim_block[%0d]: got %b want bit2=0 and others granted", k, obs_ready);
            else n_pass++;
        end
        req_valid = 4'b0100;
        set_rx1(2);
        step();
        n_checks++;
        if (obs_ready !== '0 || obs_done1 !== 4'b0100) $display("FAIL lim_rsp: got ready %b done1 %b want 0000 0100", obs_ready, obs_done1);
        else n_pass++;
        step();
        n_checks++;
        if (obs_ready !== 4'b0100 || obs_done1 !== '0) $display("FAIL lim_reopen: got ready %b done1 %b want 0100 0000", obs_ready, obs_done1);
        else n_pass++;
        test_drain();
    endtask

    task automatic test_almostfull();
        int p0, wr_cnt;
        p0 = ptr_m;
        req_valid = '1;
        for (int k = 0; k < 3; k++) step();
        tx_c1_almostfull = 1'b1;
        wr_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (obs_wrvalid === 1'b1) wr_cnt++;
            n_checks++;
            if (obs_ready !== '0) $display("FAIL af_block[%0d]: got %b want 0000", k, obs_ready);
            else n_pass++;
        end
        n_checks++;
        if (wr_cnt > 1) $display("FAIL af_slack: got %0d writes want <=1", wr_cnt);
        else n_pass++;
        tx_c1_almostfull = 1'b0;
        step();
        n_checks++;
        if (obs_ready !== (N'(1) << ((p0 + 3) % N))) $display("FAIL af_resume: got %b want %b", obs_ready, N'(1) << ((p0 + 3) % N));
        else n_pass++;
        test_drain();
    endtask

    task automatic test_same_cycle();
        req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) step();
        set_rx0(1);
        set_rx1(1);
        step();
        n_checks++;
        if (obs_ready !== 4'b0010 || obs_done0 !== 4'b0010 || obs_done1 !== 4'b0010)
            $display("FAIL same_cycle: got ready %b done %b/%b want 0010 0010/0010", obs_ready, obs_done0, obs_done1);
        else n_pass++;
        req_valid = '0;
        step();
        n_checks++;
        if (obs_done0 !== '0 || obs_done1 !== '0) $display("FAIL same_pulse: got %b/%b want 0000/0000", obs_done0, obs_done1);
        else n_pass++;
        set_rx0(1);
        set_rx1(1);
        step();
        n_checks++;
        if (obs_idle !== 1'b1 || obs_err !== 1'b0) $display("FAIL same_net: got idle %b err %b want 1 0", obs_idle, obs_err);
        else n_pass++;
    endtask

    task automatic test_unexpected();
        req_valid = '0;
        set_rx1(3);
        step();
        n_checks++;
        if (obs_err !== 1'b1 || obs_idle !== 1'b1) $display("FAIL unexp: got err %b idle %b want 1 1", obs_err, obs_idle);
        else n_pass++;
        step();
        n_checks++;
        if (obs_err !== 1'b1) $display("FAIL unexp_sticky: got %b want 1", obs_err);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        req_valid = '1;
        for (int k = 0; k < 3; k++) step();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== '0 || tx_c1_wrvalid !== 1'b0) $display("FAIL arst_ctrl: got ready %b wrvalid %b want 0000 0", req_ready, tx_c1_wrvalid);
        else n_pass++;
        n_checks++;
        if (tx_c1_header !== '0 || tx_c1_data !== '0) $display("FAIL arst_payload: got hdr %h want 0", tx_c1_header);
        else n_pass++;
        n_checks++;
        if (err_unexpected_rsp !== 1'b0 || idle !== 1'b1) $display("FAIL arst_flags: got err %b idle %b want 0 1", err_unexpected_rsp, idle);
        else n_pass++;
        lp_initdone = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (obs_ready !== '0) $display("FAIL arst_nolink[%0d]: got %b want 0000", k, obs_ready);
            else n_pass++;
        end
        lp_initdone = 1'b1;
        step();
        n_checks++;
        if (obs_ready !== 4'b0001) $display("FAIL arst_first: got %b want 0001", obs_ready);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_round_robin();
        test_outstanding_limit();
        test_almostfull();
        test_same_cycle();
        test_unexpected();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
